// File: rtl/alu_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   MUL_WIDTH   : operand/result width (product is 2*MUL_WIDTH)
//   MUL_CNT_W   : iteration counter width
//   mul_state_t : control FSM states
package package_alu;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_t;

endpackage

// File: rtl/alu_multiplier_mul_step.sv
// One shift-add iteration, purely combinational.
//   i_acc   : current 2*WIDTH accumulator
//   i_mcand : unsigned multiplicand
//   i_bit   : current multiplier bit
//   i_pos   : bit position (iteration index)
//   o_acc   : accumulator after this iteration
module mul_step
  import package_alu::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic               i_bit,
  input  logic [CNT_W-1:0]   i_pos,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_addend;

  always_comb begin
    w_addend = '0;
    if (i_bit) begin
      w_addend = {{WIDTH{1'b0}}, i_mcand} << i_pos;
    end
    o_acc = i_acc + w_addend;
  end

endmodule

// File: rtl/alu_multiplier.sv
// Iterative 32x32 shift-add multiplier for the ALU execute stage.
// Returns the low or high half of the signed/unsigned product.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   din_a, din_b        : multiplicand, multiplier
//   is_signed, high_sel : two's-complement operands; return upper half
//   out_valid/out_ready : result handshake
//   dout                : selected product half (registered)
//   busy                : unit is not IDLE
module alu_multiplier
  import package_alu::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             is_signed,
  input  logic             high_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mul_state_t r_state, w_state_next;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic               r_high;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dout;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign dout      = r_dout;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == CALC) && (r_cnt == CNT_W'(WIDTH - 1));

  // Magnitudes as unsigned; the most negative value maps onto itself,
  // which is its correct unsigned magnitude.
  assign w_abs_a = (is_signed && din_a[WIDTH-1]) ? (~din_a + WIDTH'(1)) : din_a;
  assign w_abs_b = (is_signed && din_b[WIDTH-1]) ? (~din_b + WIDTH'(1)) : din_b;

  mul_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_bit   (r_mplier[0]),
    .i_pos   (r_cnt),
    .o_acc   (w_acc_next)
  );

  // Sign is applied to the final sum of the last iteration, so the
  // result register is loaded on the same edge as the last add.
  assign w_prod = r_neg ? (~w_acc_next + (2*WIDTH)'(1)) : w_acc_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = CALC;
      CALC:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_neg       <= 1'b0;
      r_high      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= w_abs_a;
      r_mplier <= w_abs_b;
      r_neg    <= is_signed & (din_a[WIDTH-1] ^ din_b[WIDTH-1]);
      r_high   <= high_sel;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == CALC) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_dout      <= r_high ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        r_out_valid <= 1'b1;
      end
    end else if ((r_state == DONE) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multiplier.sv
module tb_alu_multiplier;
  import package_alu::*;

  localparam int unsigned W = MUL_WIDTH;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din_a;
  logic [W-1:0] din_b;
  logic         is_signed;
  logic         high_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         busy;

  alu_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .din_b     (din_b),
    .is_signed (is_signed),
    .high_sel  (high_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        h;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic h);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic [63:0]        p;
    if (s) begin
      sa  = $signed({{32{a[31]}}, a});
      sbv = $signed({{32{b[31]}}, b});
      p   = sa * sbv;
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    return h ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic h, input logic [31:0] exp);
    @(negedge clk);
    din_a     = a;
    din_b     = b;
    is_signed = s;
    high_sel  = h;
    in_valid  = 1'b1;
    check("in_ready_at_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(exp);
  endtask

  // Cycle numbering: the accept cycle is 0, so right after the accept
  // edge we are in cycle 1.
  task automatic wait_result(input string name, input int exp_cyc);
    int cyc;
    bit seen;
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_out_valid expected=out_valid", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (exp_cyc > 0) check({name, "_latency"}, cyc, exp_cyc);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected actual=0x%08h expected=no_result", name, dout);
    end else begin
      check(name, dout, sb.pop_front());
    end
  endtask

  task automatic finish_handshake(input string name);
    @(posedge clk);
    #1;
    check({name, "_ov_clear"}, {31'b0, out_valid}, 32'd0);
    check({name, "_idle"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rexp;
    logic        rs, rh;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din_a     = '0;
    din_b     = '0;
    is_signed = 1'b0;
    high_sel  = 1'b0;
    out_ready = 1'b1;

    vecs.push_back('{32'h0000A5A5, 32'h00005A5A, 1'b0, 1'b0, 32'h3A763E02});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001});
    vecs.push_back('{32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFEB});
    vecs.push_back('{32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000000});
    vecs.push_back('{32'h00000000, 32'h12345678, 1'b0, 1'b0, 32'h00000000});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000});
    vecs.push_back('{32'h80000000, 32'h00000002, 1'b0, 1'b1, 32'h00000001});
    vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 32'hC0000000});
    vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 32'h80000000});

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].h, vecs[i].exp);
      wait_result($sformatf("vec%0d", i), 33);
      finish_handshake($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rs   = 1'($urandom_range(0, 1));
      rh   = 1'($urandom_range(0, 1));
      rexp = ref_mul(ra, rb, rs, rh);
      accept(ra, rb, rs, rh, rexp);
      wait_result($sformatf("rnd%0d", i), 33);
      finish_handshake($sformatf("rnd%0d", i));
    end

    // Backpressure plus ignored requests during CALC.
    out_ready = 1'b0;
    rexp = ref_mul(32'h00001234, 32'h00005678, 1'b0, 1'b0);
    accept(32'h00001234, 32'h00005678, 1'b0, 1'b0, rexp);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      din_a     = $urandom;
      din_b     = $urandom;
      is_signed = 1'b1;
      high_sel  = 1'b1;
      check("calc_in_ready", {31'b0, in_ready}, 32'd0);
      check("calc_busy", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("bp_result", 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_dout_hold", dout, rexp);
      check("bp_ov_hold", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    finish_handshake("bp");

    // Reset in the middle of CALC.
    accept(32'hDEADBEEF, 32'h00000003, 1'b0, 1'b0, ref_mul(32'hDEADBEEF, 32'h3, 1'b0, 1'b0));
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_dout", dout, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    accept(32'd6, 32'd7, 1'b0, 1'b0, 32'd42);
    wait_result("after_reset", 33);
    finish_handshake("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multiplier.md
# alu_multiplier

Iterative shift-add 32x32 integer multiplier in the ALU execute stage. Consumes operand pairs already chosen by the ALU operand-select mux and returns the low or high 32-bit half of the product, so it serves MULL/UMULH-style operations. Valid/ready handshakes on both sides let the pipeline stall while the unit is busy.

## Interface
- WIDTH, 32, operand and result width; product is internally 2*WIDTH
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operand pair and control presented
- in_ready  output  1  unit can accept a request (state IDLE)
- din_a  input  WIDTH  multiplicand, from the operand mux
- din_b  input  WIDTH  multiplier
- is_signed  input  1  1: two's-complement operands; 0: unsigned
- high_sel  input  1  1: return product[2*WIDTH-1:WIDTH]; 0: return product[WIDTH-1:0]
- out_valid  output  1  dout holds a result
- out_ready  input  1  consumer takes the result
- dout  output  WIDTH  selected product half
- busy  output  1  state is not IDLE

## Operation
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch din_a, din_b, is_signed and high_sel; clear the 2*WIDTH accumulator and the iteration counter; go to CALC.
- Signed preprocessing happens at accept:
  - Latch |din_a| and |din_b| as WIDTH-bit unsigned values. |0x80000000| = 0x80000000 is correct as unsigned.
  - Record neg = is_signed & (a[MSB] ^ b[MSB]).
- CALC:
  - Runs exactly WIDTH cycles. No early termination, even for zero operands.
  - Each cycle: if multiplier bit0 = 1, add the multiplicand to the accumulator at the current bit position. Shift the multiplier right. Increment the counter.
  - All arithmetic is 2*WIDTH bits and unsigned; no overflow is possible.
- CALC→DONE: when the counter reaches WIDTH-1 on that cycle.
  - Form the product as neg ? (~acc+1) : acc, in 2*WIDTH bits.
  - Register the selected half into dout.
  - Set out_valid=1.
- DONE:
  - dout and out_valid are held stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE and clear out_valid.
  - A new request is not accepted in that same cycle.
- Inputs are ignored outside IDLE; in_valid during CALC/DONE has no effect.
- Reset values:
  - state=IDLE, in_ready=1 (it is combinational from state), busy=0, out_valid=0, dout=0.
  - Accumulator, counter and operand latches are all 0.
- Reset mid-operation (CALC or DONE): the operation is abandoned and the result is never presented. The next accepted request computes correctly.

## Timing
- Accept edge = cycle 0.
- CALC occupies cycles 1..WIDTH.
- out_valid rises on the edge ending cycle WIDTH, so it is visible in cycle WIDTH+1. Latency is 33 cycles for WIDTH=32.
- Minimum spacing between accepts is WIDTH+2 cycles: accept, WIDTH calc cycles, one DONE/handshake cycle, then IDLE.
- in_ready and busy are pure decodes of the state register; no combinational path from in_valid.
- dout and out_valid are registered.
- Consumer backpressure: out_ready may stay low indefinitely; dout must not change while waiting.

## Structure
- package_alu holds:
  - the state typedef (IDLE, CALC, DONE);
  - MUL_WIDTH = 32;
  - the counter width constant $clog2(MUL_WIDTH).
- Sub-module `mul_step`: purely combinational add-and-shift of one iteration. Inputs are acc, multiplicand, multiplier bit and position; output is next acc.
- The top module holds the FSM, counter, operand/sign latches and output register.

## Test plan
- Unsigned low half: a=0x0000A5A5, b=0x00005A5A, is_signed=0, high_sel=0, out_ready=1 → dout=0x3A763E02. out_valid first seen 33 cycles after accept.
- Unsigned high half: a=b=0xFFFFFFFF, is_signed=0, high_sel=1 → dout=0xFFFFFFFE. The same operands with high_sel=0 → dout=0x00000001.
- Signed mixed sign: a=0xFFFFFFFD (-3), b=0x00000007, is_signed=1 → low half 0xFFFFFFEB, high half 0xFFFFFFFF.
- Signed corner: a=b=0x80000000, is_signed=1 → high 0x40000000, low 0x00000000.
- Backpressure: after a result, hold out_ready=0 for 5 cycles → dout and out_valid stable, in_ready=0 throughout. Also assert in_valid with different operands during CALC → the result is unaffected.
- Reset mid-CALC: pull rst_n low at cycle 10 after accept → out_valid=0, dout=0 and in_ready=1 immediately. A following request a=6, b=7 → dout=42.
